// File: rtl/ysyx_23060208_clint_axil.sv
// ---------------------------------------------------------------------------
// ysyx_23060208_clint_axil
//   AXI-Lite CLINT for the ysyx_23060208 core. Holds a 64-bit mtime with a
//   clock prescaler, an optional 64-bit mtimecmp and the msip bit, and drives
//   the machine timer / software interrupt lines into the CSR unit.
//
//   Build option: YSYX_CLINT_MTIMECMP_EN
//     defined   -> mtimecmp storage and a registered mtip are implemented.
//     undefined -> mtimecmp offsets read 0 / ignore writes (OKAY), mtip = 0.
//
// Parameters
//   DATA_WIDTH  AXI-Lite address/data width (32 only)
//   BASE_ADDR   base of the CLINT window
//   TICK_DIV    mtime advances once every TICK_DIV clocks (>= 1)
//
// Ports
//   clk, rst               single clock, synchronous active-high reset
//   clint_ar* / clint_r*   AXI-Lite read address / read data channels
//   clint_aw* / clint_w*   AXI-Lite write address / write data channels
//   clint_b*               AXI-Lite write response channel
//   mtip, msip             machine timer / software interrupt pending
//
// Register map (offset from BASE_ADDR, word-aligned addresses only):
//   0x0000 msip, 0x4000/0x4004 mtimecmp lo/hi, 0xBFF8/0xBFFC mtime lo/hi.
//   Anything else reads 0 and answers DECERR.
// ---------------------------------------------------------------------------
module ysyx_23060208_clint_axil #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int          TICK_DIV   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] clint_araddr,
  input  logic                  clint_arvalid,
  output logic                  clint_arready,
  output logic [DATA_WIDTH-1:0] clint_rdata,
  output logic [1:0]            clint_rresp,
  output logic                  clint_rvalid,
  input  logic                  clint_rready,
  input  logic [DATA_WIDTH-1:0] clint_awaddr,
  input  logic                  clint_awvalid,
  output logic                  clint_awready,
  input  logic [DATA_WIDTH-1:0] clint_wdata,
  input  logic [3:0]            clint_wstrb,
  input  logic                  clint_wvalid,
  output logic                  clint_wready,
  output logic [1:0]            clint_bresp,
  output logic                  clint_bvalid,
  input  logic                  clint_bready,
  output logic                  mtip,
  output logic                  msip
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [DATA_WIDTH-1:0] ADDR_MSIP  = BASE_ADDR + 32'h0000;
  localparam logic [DATA_WIDTH-1:0] ADDR_CMPLO = BASE_ADDR + 32'h4000;
  localparam logic [DATA_WIDTH-1:0] ADDR_CMPHI = BASE_ADDR + 32'h4004;
  localparam logic [DATA_WIDTH-1:0] ADDR_TLO   = BASE_ADDR + 32'hBFF8;
  localparam logic [DATA_WIDTH-1:0] ADDR_THI   = BASE_ADDR + 32'hBFFC;

  localparam logic [2:0] SEL_NONE  = 3'd0;
  localparam logic [2:0] SEL_MSIP  = 3'd1;
  localparam logic [2:0] SEL_CMPLO = 3'd2;
  localparam logic [2:0] SEL_CMPHI = 3'd3;
  localparam logic [2:0] SEL_TLO   = 3'd4;
  localparam logic [2:0] SEL_THI   = 3'd5;

  localparam logic R_IDLE = 1'b0;
  localparam logic R_RESP = 1'b1;

  localparam logic [1:0] W_IDLE    = 2'd0;
  localparam logic [1:0] W_WAIT_W  = 2'd1;
  localparam logic [1:0] W_WAIT_AW = 2'd2;
  localparam logic [1:0] W_RESP    = 2'd3;

  // Prescaler width; a 1-bit counter is kept even for TICK_DIV == 1.
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  function automatic logic [2:0] f_decode(input logic [DATA_WIDTH-1:0] a);
    if (a == ADDR_MSIP)  return SEL_MSIP;
    if (a == ADDR_CMPLO) return SEL_CMPLO;
    if (a == ADDR_CMPHI) return SEL_CMPHI;
    if (a == ADDR_TLO)   return SEL_TLO;
    if (a == ADDR_THI)   return SEL_THI;
    return SEL_NONE;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [63:0]           r_mtime;
  logic [DIV_W-1:0]      r_div_cnt;
  logic                  r_msip;

  logic                  r_rstate;
  logic [31:0]           r_rdata;
  logic [1:0]            r_rresp;

  logic [1:0]            r_wstate;
  logic [DATA_WIDTH-1:0] r_awaddr_q;
  logic [31:0]           r_wdata_q;
  logic [3:0]            r_wstrb_q;
  logic [1:0]            r_bresp;

`ifdef YSYX_CLINT_MTIMECMP_EN
  logic [63:0]           r_mtimecmp;
  logic                  r_mtip;
`endif

  // -------------------------------------------------------------------------
  // Prescaler
  // -------------------------------------------------------------------------
  logic        w_tick;
  logic [63:0] w_mtime_inc;

  assign w_tick      = (r_div_cnt == DIV_LAST);
  assign w_mtime_inc = r_mtime + {63'b0, w_tick};

  // -------------------------------------------------------------------------
  // Write channel handshakes
  // -------------------------------------------------------------------------
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_commit;
  logic [DATA_WIDTH-1:0] w_waddr;
  logic [31:0]           w_wdata;
  logic [3:0]            w_wstrb;
  logic [2:0]            w_wr_sel;
  logic [1:0]            w_wr_resp;

  assign clint_awready = (r_wstate == W_IDLE) || (r_wstate == W_WAIT_AW);
  assign clint_wready  = (r_wstate == W_IDLE) || (r_wstate == W_WAIT_W);
  assign clint_bvalid  = (r_wstate == W_RESP);
  assign clint_bresp   = r_bresp;

  assign w_aw_hs = clint_awvalid && clint_awready;
  assign w_w_hs  = clint_wvalid  && clint_wready;

  // The register update fires on the edge where the later of AW/W lands.
  assign w_commit = ((r_wstate == W_IDLE)    && w_aw_hs && w_w_hs) ||
                    ((r_wstate == W_WAIT_W)  && w_w_hs) ||
                    ((r_wstate == W_WAIT_AW) && w_aw_hs);

  // Whichever half arrived first was parked in the _q registers.
  assign w_waddr   = (r_wstate == W_WAIT_W)  ? r_awaddr_q : clint_awaddr;
  assign w_wdata   = (r_wstate == W_WAIT_AW) ? r_wdata_q  : clint_wdata;
  assign w_wstrb   = (r_wstate == W_WAIT_AW) ? r_wstrb_q  : clint_wstrb;
  assign w_wr_sel  = f_decode(w_waddr);
  assign w_wr_resp = (w_wr_sel == SEL_NONE) ? RESP_DECERR : RESP_OKAY;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate   <= W_IDLE;
      r_awaddr_q <= '0;
      r_wdata_q  <= '0;
      r_wstrb_q  <= '0;
      r_bresp    <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_commit) begin
            r_wstate <= W_RESP;
            r_bresp  <= w_wr_resp;
          end else if (w_aw_hs) begin
            r_awaddr_q <= clint_awaddr;
            r_wstate   <= W_WAIT_W;
          end else if (w_w_hs) begin
            r_wdata_q <= clint_wdata;
            r_wstrb_q <= clint_wstrb;
            r_wstate  <= W_WAIT_AW;
          end
        end
        W_WAIT_W, W_WAIT_AW: begin
          if (w_commit) begin
            r_wstate <= W_RESP;
            r_bresp  <= w_wr_resp;
          end
        end
        W_RESP: if (clint_bready) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // mtime / prescaler / msip
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime   <= '0;
      r_div_cnt <= '0;
      r_msip    <= 1'b0;
    end else begin
      r_mtime   <= w_mtime_inc;
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      if (w_commit) begin
        case (w_wr_sel)
          SEL_MSIP: if (w_wstrb[0]) r_msip <= w_wdata[0];
          // Unwritten bytes keep the incremented value; any mtime write
          // restarts the prescaler period.
          SEL_TLO: begin
            r_mtime[31:0] <= f_merge(w_mtime_inc[31:0], w_wdata, w_wstrb);
            r_div_cnt     <= '0;
          end
          SEL_THI: begin
            r_mtime[63:32] <= f_merge(w_mtime_inc[63:32], w_wdata, w_wstrb);
            r_div_cnt      <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign msip = r_msip;

  // -------------------------------------------------------------------------
  // mtimecmp / mtip
  // -------------------------------------------------------------------------
`ifdef YSYX_CLINT_MTIMECMP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtimecmp <= '1;
      r_mtip     <= 1'b0;
    end else begin
      // Compares the values as they stood before this edge.
      r_mtip <= (r_mtime >= r_mtimecmp);
      if (w_commit) begin
        case (w_wr_sel)
          SEL_CMPLO: r_mtimecmp[31:0]  <= f_merge(r_mtimecmp[31:0],  w_wdata, w_wstrb);
          SEL_CMPHI: r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], w_wdata, w_wstrb);
          default: ;
        endcase
      end
    end
  end

  assign mtip = r_mtip;
`else
  assign mtip = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Read channel
  // -------------------------------------------------------------------------
  logic [2:0]  w_rd_sel;
  logic [31:0] w_rd_data;
  logic [1:0]  w_rd_resp;

  assign w_rd_sel  = f_decode(clint_araddr);
  assign w_rd_resp = (w_rd_sel == SEL_NONE) ? RESP_DECERR : RESP_OKAY;

  always_comb begin
    w_rd_data = '0;
    case (w_rd_sel)
      SEL_MSIP:  w_rd_data = {31'b0, r_msip};
`ifdef YSYX_CLINT_MTIMECMP_EN
      SEL_CMPLO: w_rd_data = r_mtimecmp[31:0];
      SEL_CMPHI: w_rd_data = r_mtimecmp[63:32];
`endif
      SEL_TLO:   w_rd_data = r_mtime[31:0];
      SEL_THI:   w_rd_data = r_mtime[63:32];
      default:   w_rd_data = '0;
    endcase
  end

  assign clint_arready = (r_rstate == R_IDLE);
  assign clint_rvalid  = (r_rstate == R_RESP);
  assign clint_rdata   = r_rdata;
  assign clint_rresp   = r_rresp;

  // Data is captured at the AR handshake, so a write landing on the same
  // edge is not visible to this read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (clint_arvalid) begin
            r_rstate <= R_RESP;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
          end
        end
        R_RESP: if (clint_rready) r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule
